// File: rtl/cordic_hyp_pipe.sv
// rtl/cordic_hyp_pipe.sv - parametrised pipelined hyperbolic CORDIC with valid/ready and whole-pipe stall
//
// Purpose: hyperbolic CORDIC micro-rotation pipeline. Per-sample mode selects
// rotation (drive z to 0: cosh/sinh/exp) or vectoring (drive y to 0: atanh/sqrt).
// Gain is not compensated; the caller pre-scales in_x.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      input handshake; in_ready is the pipe-wide enable
//   in_mode                  0 = rotation, 1 = vectoring
//   in_x, in_y, in_z         signed Q(WIDTH-FRAC).FRAC vector and angle
//   in_tag                   passthrough tag
//   out_valid / out_ready    output handshake
//   out_x, out_y, out_z      result vector and angle
//   out_tag                  tag of this result
//   out_range_err            rotation-mode |in_z| was beyond the convergence limit

module cordic_hyp_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 12,
    parameter int STAGES = 16,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_range_err
);

    // Shift amount for stage s: 1,2,3,4,4,5,...,13,13,14,... where each k in
    // the series 4,13,40,... (k_next = 3k+1) is executed twice so the
    // hyperbolic iteration converges.
    function automatic int shift_of(input int s);
        int k;
        int rep;
        bit rep_done;
        k        = 1;
        rep      = 4;
        rep_done = 1'b0;
        for (int i = 0; i < s; i++) begin
            if (k == rep && !rep_done) begin
                rep_done = 1'b1;
            end else begin
                if (k == rep) begin
                    rep      = 3 * rep + 1;
                    rep_done = 1'b0;
                end
                k++;
            end
        end
        return k;
    endfunction

    // round(atanh(2^-k) * 2^FRAC), from the odd power series
    // sum 2^(-k(2n+1))/(2n+1) evaluated in Q2.62 integer arithmetic.
    function automatic logic [WIDTH-1:0] atanh_const(input int k);
        logic [63:0] acc;
        logic [63:0] rounded;
        int          p;
        acc = '0;
        for (int n = 0; n < 32; n++) begin
            p = k * (2 * n + 1);
            if (p < 63) begin
                acc = acc + ((64'd1 << (62 - p)) / 64'(2 * n + 1));
            end
        end
        rounded = (acc + (64'd1 << (61 - FRAC))) >> (62 - FRAC);
        return rounded[WIDTH-1:0];
    endfunction

    // Convergence limit 1.1180 in the input format, rounded to nearest.
    localparam logic [63:0]    Z_LIM_FULL = ((64'd11180 << FRAC) + 64'd5000) / 64'd10000;
    localparam logic [WIDTH:0] Z_LIMIT    = Z_LIM_FULL[WIDTH:0];

    // Index 0 is the input register; index s+1 is the output of micro-rotation s.
    logic                    r_v    [0:STAGES];
    logic                    r_mode [0:STAGES];
    logic                    r_err  [0:STAGES];
    logic [TAG_W-1:0]        r_tag  [0:STAGES];
    logic signed [WIDTH-1:0] r_x    [0:STAGES];
    logic signed [WIDTH-1:0] r_y    [0:STAGES];
    logic signed [WIDTH-1:0] r_z    [0:STAGES];

    logic signed [WIDTH-1:0] w_nx [0:STAGES-1];
    logic signed [WIDTH-1:0] w_ny [0:STAGES-1];
    logic signed [WIDTH-1:0] w_nz [0:STAGES-1];

    logic           w_en;
    logic [WIDTH:0] w_z_ext;
    logic [WIDTH:0] w_z_abs;
    logic           w_range;

    // One enable for the whole pipe: everything advances unless the final
    // result is being held for the consumer.
    assign w_en     = !r_v[STAGES] || out_ready;
    assign in_ready = w_en;

    // Magnitude in WIDTH+1 bits so the most negative input does not overflow.
    assign w_z_ext = {in_z[WIDTH-1], in_z};
    assign w_z_abs = w_z_ext[WIDTH] ? -w_z_ext : w_z_ext;
    assign w_range = !in_mode && (w_z_abs > Z_LIMIT);

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            localparam int                      K   = shift_of(s);
            localparam logic signed [WIDTH-1:0] A_K = atanh_const(K);

            logic                    w_d;
            logic signed [WIDTH-1:0] w_xs;
            logic signed [WIDTH-1:0] w_ys;

            // w_d = 1 means d = +1.
            assign w_d  = r_mode[s] ? r_y[s][WIDTH-1] : ~r_z[s][WIDTH-1];
            assign w_xs = r_x[s] >>> K;
            assign w_ys = r_y[s] >>> K;

            assign w_nx[s] = w_d ? (r_x[s] + w_ys) : (r_x[s] - w_ys);
            assign w_ny[s] = w_d ? (r_y[s] + w_xs) : (r_y[s] - w_xs);
            assign w_nz[s] = w_d ? (r_z[s] - A_K)  : (r_z[s] + A_K);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= STAGES; i++) begin
                r_v[i]    <= 1'b0;
                r_mode[i] <= 1'b0;
                r_err[i]  <= 1'b0;
                r_tag[i]  <= '0;
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_z[i]    <= '0;
            end
        end else if (w_en) begin
            r_v[0]    <= in_valid;
            r_mode[0] <= in_mode;
            r_err[0]  <= w_range;
            r_tag[0]  <= in_tag;
            r_x[0]    <= in_x;
            r_y[0]    <= in_y;
            r_z[0]    <= in_z;
            // Bubbles advance like samples; nothing is collapsed.
            for (int s = 0; s < STAGES; s++) begin
                r_v[s+1]    <= r_v[s];
                r_mode[s+1] <= r_mode[s];
                r_err[s+1]  <= r_err[s];
                r_tag[s+1]  <= r_tag[s];
                r_x[s+1]    <= w_nx[s];
                r_y[s+1]    <= w_ny[s];
                r_z[s+1]    <= w_nz[s];
            end
        end
    end

    assign out_valid     = r_v[STAGES];
    assign out_x         = r_x[STAGES];
    assign out_y         = r_y[STAGES];
    assign out_z         = r_z[STAGES];
    assign out_tag       = r_tag[STAGES];
    assign out_range_err = r_err[STAGES];

endmodule

// File: tb/tb_cordic_hyp_pipe.sv
// tb/tb_cordic_hyp_pipe.sv - scoreboard testbench for cordic_hyp_pipe

module tb_cordic_hyp_pipe;

    localparam int WIDTH  = 16;
    localparam int FRAC   = 12;
    localparam int STAGES = 16;
    localparam int TAG_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic signed [WIDTH-1:0] in_x;
    logic signed [WIDTH-1:0] in_y;
    logic signed [WIDTH-1:0] in_z;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_x;
    logic signed [WIDTH-1:0] out_y;
    logic signed [WIDTH-1:0] out_z;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_range_err;

    always #5 clk = ~clk;

    cordic_hyp_pipe #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .STAGES(STAGES),
        .TAG_W (TAG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_z         (in_z),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_z        (out_z),
        .out_tag      (out_tag),
        .out_range_err(out_range_err)
    );

    // Expected result; a negative tolerance means that field is not checked,
    // ecyc < 0 means latency is not checked for this sample.
    typedef struct {
        logic [TAG_W-1:0] tag;
        int               ex, ey, ez;
        int               tx, ty, tz;
        logic             err;
        int               ecyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   n_checks      = 0;
    int   n_errors      = 0;
    int   cyc           = 0;
    int   stim_timeouts = 0;
    logic exp_reset     = 1'b0;
    logic exp_idle      = 1'b0;
    logic chk_empty     = 1'b0;
    logic bp_en         = 1'b0;

    logic                    prev_stall = 1'b0;
    logic signed [WIDTH-1:0] sx, sy, sz;
    logic [TAG_W-1:0]        stag;
    logic                    serr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic check_val(input string name, input int act, input int exp, input int tol);
        int diff;
        n_checks++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%04h), expected %0d +/- %0d at cycle %0d",
                     name, act, act[15:0], exp, tol, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        if (exp_reset) begin
            check_val("reset out_valid", int'(out_valid), 0, 0);
            check_val("reset out_x", int'(out_x), 0, 0);
            check_val("reset out_y", int'(out_y), 0, 0);
            check_val("reset out_z", int'(out_z), 0, 0);
            check_val("reset out_tag", int'(out_tag), 0, 0);
            check_val("reset out_range_err", int'(out_range_err), 0, 0);
            check_val("reset in_ready", int'(in_ready), 1, 0);
        end
        if (exp_idle) check_val("idle after reset out_valid", int'(out_valid), 0, 0);
        if (chk_empty) begin
            check_val("scoreboard drained (entries left)", sb.size(), 0, 0);
            check_val("input handshake timeouts", stim_timeouts, 0, 0);
        end
        if (!rst && prev_stall) begin
            check_val("stall out_valid held", int'(out_valid), 1, 0);
            check_val("stall out_x held", int'(out_x), int'(sx), 0);
            check_val("stall out_y held", int'(out_y), int'(sy), 0);
            check_val("stall out_z held", int'(out_z), int'(sz), 0);
            check_val("stall out_tag held", int'(out_tag), int'(stag), 0);
            check_val("stall out_range_err held", int'(out_range_err), int'(serr), 0);
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected output: got tag %0d x %0d with empty scoreboard, expected none",
                         out_tag, out_x);
            end else begin
                mon_e = sb.pop_front();
                check_val("out_tag", int'(out_tag), int'(mon_e.tag), 0);
                check_val("out_range_err", int'(out_range_err), int'(mon_e.err), 0);
                if (mon_e.tx >= 0) check_val("out_x", int'(out_x), mon_e.ex, mon_e.tx);
                if (mon_e.ty >= 0) check_val("out_y", int'(out_y), mon_e.ey, mon_e.ty);
                if (mon_e.tz >= 0) check_val("out_z", int'(out_z), mon_e.ez, mon_e.tz);
                if (mon_e.ecyc >= 0) check_val("latency cycle", cyc, mon_e.ecyc, 0);
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        sx   = out_x;
        sy   = out_y;
        sz   = out_z;
        stag = out_tag;
        serr = out_range_err;
    end

    // Consumer backpressure: random when enabled, otherwise always ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Presents one sample and holds it until the handshake completes. The
    // transfer edge is cyc+1; the last stage register loads STAGES edges later.
    task automatic send(input logic mode, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [TAG_W-1:0] tag,
                        input int ex, input int ey, input int ez,
                        input int tx, input int ty, input int tz,
                        input logic err, input bit lat);
        exp_t e;
        int   waited;
        in_valid = 1'b1;
        in_mode  = mode;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_tag   = tag;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.tag  = tag;
                e.ex   = ex;
                e.ey   = ey;
                e.ez   = ez;
                e.tx   = tx;
                e.ty   = ty;
                e.tz   = tz;
                e.err  = err;
                e.ecyc = lat ? (cyc + 1 + STAGES) : -1;
                sb.push_back(e);
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 1000) begin
                stim_timeouts++;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_z     = '0;
    endtask

    // Directed vectors with hand-computed results (x pre-scaled by 1/An).
    task automatic send_vec(input int idx, input logic [TAG_W-1:0] tag, input bit lat);
        case (idx)
            0: send(1'b0, 16'h1352, 16'h0000, 16'h0000, tag, 'h1000, 0, 0, 4, 4, 2, 1'b0, lat);
            1: send(1'b0, 16'h1352, 16'h0000, 16'h0800, tag, 'h120B, 'h0856, 0, 4, 4, -1, 1'b0, lat);
            2: send(1'b0, 16'h1352, 16'h0000, 16'hF800, tag, 'h120B, s16(16'hF7AA), 0, 4, 4, -1, 1'b0, lat);
            default: send(1'b1, 16'h1000, 16'h0800, 16'h0000, tag, 'h0B7A, 0, 'h08CA, 6, 4, 4, 1'b0, lat);
        endcase
    endtask

    task automatic pulse_flag_cycle;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_empty = 1'b1;
        pulse_flag_cycle();
        chk_empty = 1'b0;
    endtask

    initial begin
        // Input presented during reset must be ignored.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_x     = 16'sh1352;
        in_y     = '0;
        in_z     = '0;
        in_tag   = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        exp_reset = 1'b1;
        pulse_flag_cycle();
        exp_reset = 1'b0;

        // Directed functional vectors, back to back, latency checked.
        for (int i = 0; i < 4; i++) send_vec(i, 4'(i), 1'b1);

        // Range flag and its boundaries (data not checked).
        send(1'b0, 16'h1352, 16'h0000, 16'h1400, 4'd4, 0, 0, 0, -1, -1, -1, 1'b1, 1'b1);
        send(1'b0, 16'h1352, 16'h0000, 16'h1000, 4'd5, 0, 0, 0, -1, -1, -1, 1'b0, 1'b1);
        send(1'b0, 16'h1352, 16'h0000, 16'h11E3, 4'd6, 0, 0, 0, -1, -1, -1, 1'b0, 1'b0);
        send(1'b0, 16'h1352, 16'h0000, 16'h11E4, 4'd7, 0, 0, 0, -1, -1, -1, 1'b1, 1'b0);
        send(1'b0, 16'h1352, 16'h0000, 16'hEE1D, 4'd8, 0, 0, 0, -1, -1, -1, 1'b0, 1'b0);
        send(1'b0, 16'h1352, 16'h0000, 16'hEE1C, 4'd9, 0, 0, 0, -1, -1, -1, 1'b1, 1'b0);
        send(1'b0, 16'h1352, 16'h0000, 16'h8000, 4'd10, 0, 0, 0, -1, -1, -1, 1'b1, 1'b0);
        send(1'b1, 16'h1000, 16'h0800, 16'h7FFF, 4'd11, 0, 0, 0, -1, -1, -1, 1'b0, 1'b0);
        drain();

        // Backpressure stream: 40 samples, tags cycling 0..15.
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) send_vec(i % 4, 4'(i % 16), 1'b0);
        drain();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with 10 samples in flight: all discarded.
        for (int i = 0; i < 10; i++) send_vec(i % 4, 4'(i), 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_reset = 1'b1;
        exp_idle  = 1'b1;
        pulse_flag_cycle();
        exp_reset = 1'b0;
        repeat (STAGES) pulse_flag_cycle();
        exp_idle = 1'b0;
        send_vec(1, 4'd12, 1'b1);
        drain();

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
